// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit: registered WIDTH-bit AND/OR/XOR/NOR with valid/ready handshakes
// on both sides. In accumulate mode a multi-beat packet is folded into a single result.
// Build option: define BITWISE_PARITY_EN to add the registered y_parity output.
module bitwise_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             acc_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
`ifdef BITWISE_PARITY_EN
    output logic             y_parity,
`endif
    output logic             y_zero
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       op_q, op_d;
    logic             mode_q, mode_d;
    logic             accept;
    logic             load;
    logic [1:0]       eff_op;
    logic [WIDTH-1:0] eff_b;
    logic [WIDTH-1:0] result;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z
    );
        case (sel)
            2'b00:   return x & z;
            2'b01:   return x | z;
            2'b10:   return x ^ z;
            default: return ~(x | z);
        endcase
    endfunction

    // The single output register can take a new result whenever it is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Inside a packet the operator comes from the first beat and b is replaced by the running fold.
    always_comb begin
        eff_op = op;
        eff_b  = b;
        if (state_q == ACCUM) begin
            eff_op = op_q;
            eff_b  = acc_q;
        end
        result = apply_op(eff_op, a, eff_b);
    end

    // Next-state logic: decide whether an accepted beat folds into acc or loads the output.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        mode_d  = mode_q;
        load    = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    op_d   = op;
                    mode_d = acc_mode;
                    if (!acc_mode || in_last) begin
                        load = 1'b1;
                    end else begin
                        acc_d   = result;
                        state_d = ACCUM;
                    end
                end
                default: begin
                    if (in_last || !mode_q) begin
                        load    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        acc_d = result;
                    end
                end
            endcase
        end
    end

    // Packet state registers; reset drops any partial accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= 2'b00;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
        end
    end

    // Output register: loads a finished result, clears valid when taken, holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_zero    <= 1'b1;
`ifdef BITWISE_PARITY_EN
            y_parity  <= 1'b0;
`endif
        end else if (load) begin
            out_valid <= 1'b1;
            y         <= result;
            y_zero    <= (result == '0);
`ifdef BITWISE_PARITY_EN
            y_parity  <= ^result;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb_bitwise_logic_unit: directed cases from the datasheet examples plus a randomized run
// against a packet-level reference model with a one-entry output slot.
// Honours BITWISE_PARITY_EN when the design is built with it.
module tb_bitwise_logic_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       acc_mode;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       y_zero;
`ifdef BITWISE_PARITY_EN
    logic       y_parity;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    bit       m_valid;
    bit [7:0] m_y;
    bit       m_inpkt;
    bit [7:0] m_acc;
    bit [1:0] m_op;
    logic     seen_ready;

    bitwise_logic_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_mode  (acc_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
`ifdef BITWISE_PARITY_EN
        .y_parity  (y_parity),
`endif
        .y_zero    (y_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // bitwise operator as named by the op code
    function automatic bit [7:0] ref_op(input bit [1:0] sel, input bit [7:0] x, input bit [7:0] z);
        bit [7:0] r;
        case (sel)
            2'd0: r = x & z;
            2'd1: r = x | z;
            2'd2: r = x ^ z;
            default: r = ~(x | z);
        endcase
        return r;
    endfunction

    function automatic bit ref_parity(input bit [7:0] v);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += v[i];
        return (ones % 2) == 1;
    endfunction

    // advance the reference model by one clock edge with the given inputs
    task automatic model_step(input bit r, input bit iv, input bit [7:0] ia, input bit [7:0] ib,
                              input bit [1:0] iop, input bit imode, input bit ilast, input bit iordy);
        bit fire;
        bit nv;
        bit [7:0] res;
        fire = iv && (!m_valid || iordy);
        if (r) begin
            m_valid = 0; m_y = 8'h00; m_inpkt = 0; m_acc = 8'h00;
        end else begin
            nv = m_valid && !iordy;
            if (fire) begin
                if (!m_inpkt) begin
                    res  = ref_op(iop, ia, ib);
                    m_op = iop;
                    if (!imode || ilast) begin
                        m_y = res; nv = 1;
                    end else begin
                        m_acc = res; m_inpkt = 1;
                    end
                end else begin
                    res = ref_op(m_op, ia, m_acc);
                    if (ilast) begin
                        m_y = res; nv = 1; m_inpkt = 0;
                    end else begin
                        m_acc = res;
                    end
                end
            end
            m_valid = nv;
        end
    endtask

    // drive one cycle of inputs, sample in_ready before the edge, then land #1 after the edge
    task automatic applyStimulus(input bit r, input bit iv, input bit [7:0] ia, input bit [7:0] ib,
                                 input bit [1:0] iop, input bit imode, input bit ilast, input bit iordy);
        rst = r; in_valid = iv; a = ia; b = ib; op = iop;
        acc_mode = imode; in_last = ilast; out_ready = iordy;
        #1;
        seen_ready = in_ready;
        @(posedge clk);
        model_step(r, iv, ia, ib, iop, imode, ilast, iordy);
        #1;
    endtask

    task automatic test_reset;
        applyStimulus(1, 0, 8'h00, 8'h00, 2'd0, 0, 0, 1);
        applyStimulus(1, 1, 8'hFF, 8'hFF, 2'd1, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b expected 0", out_valid); end
        checks++;
        if (y !== 8'h00) begin errors++; $display("[TB] FAIL reset_y got %h expected 00", y); end
        checks++;
        if (y_zero !== 1'b1) begin errors++; $display("[TB] FAIL reset_y_zero got %0b expected 1", y_zero); end
`ifdef BITWISE_PARITY_EN
        checks++;
        if (y_parity !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity got %0b expected 0", y_parity); end
`endif
        applyStimulus(0, 0, 8'h00, 8'h00, 2'd0, 0, 0, 1);
        checks++;
        if (seen_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b expected 1", seen_ready); end
    endtask

    task automatic test_single_or;
        applyStimulus(0, 1, 8'b00011100, 8'b00010001, 2'd1, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL or_out_valid got %0b expected 1", out_valid); end
        checks++;
        if (y !== 8'b00011101) begin errors++; $display("[TB] FAIL or_y got %b expected 00011101", y); end
        checks++;
        if (y_zero !== 1'b0) begin errors++; $display("[TB] FAIL or_y_zero got %0b expected 0", y_zero); end
`ifdef BITWISE_PARITY_EN
        checks++;
        if (y_parity !== 1'b0) begin errors++; $display("[TB] FAIL or_parity got %0b expected 0", y_parity); end
`endif
        applyStimulus(0, 0, 8'h00, 8'h00, 2'd0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL or_drain got %0b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_y [4];
        exp_y[0] = 8'b10110000; exp_y[1] = 8'b11110110;
        exp_y[2] = 8'b01000110; exp_y[3] = 8'b00001001;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 8'b10110010, 8'b11110100, k[1:0], 0, 0, 1);
            checks++;
            if (out_valid !== 1'b1 || y !== exp_y[k]) begin
                errors++;
                $display("[TB] FAIL b2b_op%0d got valid=%0b y=%b expected valid=1 y=%b", k, out_valid, y, exp_y[k]);
            end
        end
`ifdef BITWISE_PARITY_EN
        checks++;
        if (y_parity !== 1'b0) begin errors++; $display("[TB] FAIL b2b_parity got %0b expected 0", y_parity); end
`endif
        applyStimulus(0, 0, 8'h00, 8'h00, 2'd0, 0, 0, 1);
    endtask

    task automatic test_accumulate;
        applyStimulus(0, 1, 8'h01, 8'h02, 2'd1, 1, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL acc_beat1 out_valid got %0b expected 0", out_valid); end
        applyStimulus(0, 1, 8'h04, 8'hFF, 2'd0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL acc_beat2 out_valid got %0b expected 0", out_valid); end
        applyStimulus(0, 1, 8'h80, 8'h55, 2'd2, 0, 1, 1);
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h87) begin
            errors++; $display("[TB] FAIL acc_result got valid=%0b y=%h expected valid=1 y=87", out_valid, y);
        end
`ifdef BITWISE_PARITY_EN
        checks++;
        if (y_parity !== 1'b0) begin errors++; $display("[TB] FAIL acc_parity87 got %0b expected 0", y_parity); end
`endif
        applyStimulus(0, 1, 8'h01, 8'h02, 2'd1, 1, 0, 1);
        applyStimulus(0, 1, 8'h04, 8'h00, 2'd3, 1, 1, 1);
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h07) begin
            errors++; $display("[TB] FAIL acc_result07 got valid=%0b y=%h expected valid=1 y=07", out_valid, y);
        end
`ifdef BITWISE_PARITY_EN
        checks++;
        if (y_parity !== 1'b1) begin errors++; $display("[TB] FAIL acc_parity07 got %0b expected 1", y_parity); end
`endif
        applyStimulus(0, 0, 8'h00, 8'h00, 2'd0, 0, 0, 1);
    endtask

    task automatic test_backpressure;
        applyStimulus(0, 1, 8'hFF, 8'h3C, 2'd0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 8'h0F, 8'hF0, 2'd1, 0, 0, 0);
            checks++;
            if (seen_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready%0d got %0b expected 0", k, seen_ready); end
            checks++;
            if (out_valid !== 1'b1 || y !== 8'h3C) begin
                errors++; $display("[TB] FAIL stall_hold%0d got valid=%0b y=%h expected valid=1 y=3c", k, out_valid, y);
            end
        end
        applyStimulus(0, 1, 8'h0F, 8'hF0, 2'd1, 0, 0, 1);
        checks++;
        if (seen_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready got %0b expected 1", seen_ready); end
        checks++;
        if (out_valid !== 1'b1 || y !== 8'hFF) begin
            errors++; $display("[TB] FAIL release_y got valid=%0b y=%h expected valid=1 y=ff", out_valid, y);
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 2'd0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_drain got %0b expected 0", out_valid); end
    endtask

    task automatic test_zero_and_reset;
        applyStimulus(0, 1, 8'hF0, 8'h0F, 2'd0, 1, 1, 1);
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h00 || y_zero !== 1'b1) begin
            errors++; $display("[TB] FAIL and_zero got valid=%0b y=%h zero=%0b expected valid=1 y=00 zero=1", out_valid, y, y_zero);
        end
        applyStimulus(0, 1, 8'hAA, 8'h01, 2'd1, 1, 0, 1);
        applyStimulus(0, 1, 8'h10, 8'h00, 2'd1, 1, 0, 1);
        applyStimulus(1, 1, 8'h40, 8'h00, 2'd1, 1, 1, 1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid got %0b expected 0", out_valid); end
        applyStimulus(0, 1, 8'h02, 8'h04, 2'd1, 1, 0, 1);
        applyStimulus(0, 1, 8'h01, 8'hFF, 2'd1, 1, 1, 1);
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h07) begin
            errors++; $display("[TB] FAIL midreset_next got valid=%0b y=%h expected valid=1 y=07", out_valid, y);
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 2'd0, 0, 0, 1);
    endtask

    task automatic test_random;
        bit       r, iv, im, il, ir;
        bit [7:0] ia, ib;
        bit [1:0] iop;
        bit       exp_ready;
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 59) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            ia  = 8'($urandom_range(0, 255));
            ib  = 8'($urandom_range(0, 255));
            iop = 2'($urandom_range(0, 3));
            im  = ($urandom_range(0, 1) == 1);
            il  = ($urandom_range(0, 2) == 0);
            ir  = ($urandom_range(0, 3) != 0);
            exp_ready = !m_valid || ir;
            applyStimulus(r, iv, ia, ib, iop, im, il, ir);
            checks++;
            if (seen_ready !== exp_ready) begin
                errors++; $display("[TB] FAIL rand_in_ready cycle %0d got %0b expected %0b", n, seen_ready, exp_ready);
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++; $display("[TB] FAIL rand_out_valid cycle %0d got %0b expected %0b", n, out_valid, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (y !== m_y || y_zero !== (m_y == 8'h00)) begin
                    errors++; $display("[TB] FAIL rand_y cycle %0d got y=%h zero=%0b expected y=%h zero=%0b", n, y, y_zero, m_y, m_y == 8'h00);
                end
`ifdef BITWISE_PARITY_EN
                checks++;
                if (y_parity !== ref_parity(m_y)) begin
                    errors++; $display("[TB] FAIL rand_parity cycle %0d got %0b expected %0b", n, y_parity, ref_parity(m_y));
                end
`endif
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 2'd0;
        acc_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        m_valid = 0; m_y = 8'h00; m_inpkt = 0; m_acc = 8'h00; m_op = 2'd0;
        seen_ready = 1'b0;
        test_reset();
        test_single_or();
        test_back_to_back();
        test_accumulate();
        test_backpressure();
        test_zero_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
